// File: rtl/orbit_update_sequencer.sv
// One orbital-physics step per frame: gravity via a shared divider,
// semi-implicit Euler update, atomic commit of the ship pixel position.
module orbit_update_sequencer #(
    parameter int CX     = 320,
    parameter int CY     = 240,
    parameter int GM     = 100,
    parameter int FRAC   = 8,
    parameter int X0     = 300,
    parameter int Y0     = 240,
    parameter int VX0    = 0,
    parameter int VY0    = 1280,
    parameter int R_MIN2 = 16,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        pause,
    output logic        div_req,
    output logic [31:0] div_num,
    output logic [31:0] div_den,
    input  logic        div_ack,
    input  logic [31:0] div_quot,
    output logic [9:0]  ship_x,
    output logic [9:0]  ship_y,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] step_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_R2, S_DIV_AX, S_DIV_AY, S_UPD_V, S_UPD_P, S_COMMIT
    } state_t;

    localparam logic signed [23:0] PX_RST = 24'(X0 * (1 << FRAC));
    localparam logic signed [23:0] PY_RST = 24'(Y0 * (1 << FRAC));
    localparam logic signed [23:0] VX_RST = 24'(VX0);
    localparam logic signed [23:0] VY_RST = 24'(VY0);
    localparam logic signed [10:0] CX_S   = 11'(CX);
    localparam logic signed [10:0] CY_S   = 11'(CY);
    localparam logic signed [23:0] XMAX   = 24'(H_RES - 1);
    localparam logic signed [23:0] YMAX   = 24'(V_RES - 1);

    state_t state_q, state_d;

    logic signed [23:0] px_q, px_d, py_q, py_d;
    logic signed [23:0] vx_q, vx_d, vy_q, vy_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
    logic [31:0]        r2_q, r2_d;
    logic [14:0]        ax_q, ax_d, ay_q, ay_d;
    logic [9:0]         ship_x_q, ship_x_d, ship_y_q, ship_y_d;
    logic [15:0]        step_q, step_d;
    logic               overrun_q, overrun_d;

    logic signed [10:0] dx_w, dy_w;
    logic signed [31:0] dx32, dy32;
    logic [31:0]        r2_sum;
    logic [10:0]        adx_w, ady_w;
    logic [14:0]        q_sat;
    logic signed [23:0] ax_s, ay_s, ipx, ipy;

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (frame_tick && !pause) state_d = S_R2;
            S_R2:     state_d = S_DIV_AX;
            S_DIV_AX: if (div_ack) state_d = S_DIV_AY;
            S_DIV_AY: if (div_ack) state_d = S_UPD_V;
            S_UPD_V:  state_d = S_UPD_P;
            S_UPD_P:  state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        div_req = (state_q == S_DIV_AX) || (state_q == S_DIV_AY);
        div_num = '0;
        div_den = '0;
        if (state_q == S_DIV_AX) begin
            div_num = (32'(GM) * 32'(adx_w)) << FRAC;
            div_den = r2_q;
        end else if (state_q == S_DIV_AY) begin
            div_num = (32'(GM) * 32'(ady_w)) << FRAC;
            div_den = r2_q;
        end
    end

    // Integer pixel part is taken as an unsigned 10-bit field before centring.
    always_comb begin
        dx_w   = $signed({1'b0, px_q[FRAC+9:FRAC]}) - CX_S;
        dy_w   = $signed({1'b0, py_q[FRAC+9:FRAC]}) - CY_S;
        dx32   = 32'(dx_w);
        dy32   = 32'(dy_w);
        r2_sum = unsigned'(dx32 * dx32 + dy32 * dy32);
        adx_w  = dx_q[10] ? 11'(-dx_q) : dx_q;
        ady_w  = dy_q[10] ? 11'(-dy_q) : dy_q;
        q_sat  = (div_quot > 32'd32767) ? 15'h7fff : div_quot[14:0];
        ax_s   = $signed({9'b0, ax_q});
        ay_s   = $signed({9'b0, ay_q});
        ipx    = px_q >>> FRAC;
        ipy    = py_q >>> FRAC;
    end

    always_comb begin
        px_d      = px_q;
        py_d      = py_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        r2_d      = r2_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        ship_x_d  = ship_x_q;
        ship_y_d  = ship_y_q;
        step_d    = step_q;
        overrun_d = overrun_q | (frame_tick && busy);
        unique case (state_q)
            S_R2: begin
                dx_d = dx_w;
                dy_d = dy_w;
                r2_d = (r2_sum < 32'(R_MIN2)) ? 32'(R_MIN2) : r2_sum;
            end
            S_DIV_AX: if (div_ack) ax_d = q_sat;
            S_DIV_AY: if (div_ack) ay_d = q_sat;
            S_UPD_V: begin
                if (dx_q > 0)      vx_d = vx_q - ax_s;
                else if (dx_q < 0) vx_d = vx_q + ax_s;
                if (dy_q > 0)      vy_d = vy_q - ay_s;
                else if (dy_q < 0) vy_d = vy_q + ay_s;
            end
            S_UPD_P: begin
                px_d = px_q + vx_q;
                py_d = py_q + vy_q;
            end
            S_COMMIT: begin
                if (ipx < 0)         ship_x_d = '0;
                else if (ipx > XMAX) ship_x_d = 10'(H_RES - 1);
                else                 ship_x_d = ipx[9:0];
                if (ipy < 0)         ship_y_d = '0;
                else if (ipy > YMAX) ship_y_d = 10'(V_RES - 1);
                else                 ship_y_d = ipy[9:0];
                step_d = step_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            px_q      <= PX_RST;
            py_q      <= PY_RST;
            vx_q      <= VX_RST;
            vy_q      <= VY_RST;
            dx_q      <= '0;
            dy_q      <= '0;
            r2_q      <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            ship_x_q  <= 10'(X0);
            ship_y_q  <= 10'(Y0);
            step_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            px_q      <= px_d;
            py_q      <= py_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            r2_q      <= r2_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            ship_x_q  <= ship_x_d;
            ship_y_q  <= ship_y_d;
            step_q    <= step_d;
            overrun_q <= overrun_d;
        end
    end

    assign ship_x     = ship_x_q;
    assign ship_y     = ship_y_q;
    assign step_count = step_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_orbit_update_sequencer.sv
// Randomized bench for orbit_update_sequencer against an integer
// reference model of the physics step and the divider handshake.
module tb_orbit_update_sequencer;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        frame_tick = 1'b0;
    logic        pause     = 1'b0;
    logic        div_req;
    logic [31:0] div_num, div_den;
    logic        div_ack   = 1'b0;
    logic [31:0] div_quot  = '0;
    logic [9:0]  ship_x, ship_y;
    logic        busy, overrun;
    logic [15:0] step_count;

    logic        tick_c = 1'b0;
    logic        req_c;
    logic [31:0] num_c, den_c;
    logic        ack_c = 1'b0;
    logic [9:0]  sx_c, sy_c;
    logic        busy_c, ovr_c;
    logic [15:0] steps_c;

    int n_checks = 0;
    int n_errors = 0;

    int m_px, m_py, m_vx, m_vy, m_steps;
    bit m_ovr;
    int first_num, first_den;

    always #5 pixel_clk = ~pixel_clk;

    orbit_update_sequencer dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .frame_tick(frame_tick), .pause(pause),
        .div_req(div_req), .div_num(div_num), .div_den(div_den),
        .div_ack(div_ack), .div_quot(div_quot),
        .ship_x(ship_x), .ship_y(ship_y), .busy(busy),
        .overrun(overrun), .step_count(step_count)
    );

    orbit_update_sequencer #(.X0(320), .Y0(240), .VX0(0), .VY0(0)) dut_c (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .frame_tick(tick_c), .pause(pause),
        .div_req(req_c), .div_num(num_c), .div_den(den_c),
        .div_ack(ack_c), .div_quot(32'd0),
        .ship_x(sx_c), .ship_y(sy_c), .busy(busy_c),
        .overrun(ovr_c), .step_count(steps_c)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap24(input int v);
        return (v <<< 8) >>> 8;
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_px = 300 * 256; m_py = 240 * 256;
        m_vx = 0; m_vy = 1280;
        m_steps = 0; m_ovr = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"}, ship_x, clampi(m_px >>> 8, 639));
        check({tag, "_y"}, ship_y, clampi(m_py >>> 8, 479));
        check({tag, "_steps"}, step_count, m_steps & 16'hffff);
        check({tag, "_ovr"}, overrun, m_ovr);
    endtask

    // One full step; tick_at/pz are busy-cycle indices (0 = never).
    task automatic run_step(input int lx, input int ly, input bit rnd_q,
                            input bit spur, input int tick_at, input int pz);
        int dx, dy, r2, ex_num[2], lat[2], q[2];
        int ph, rc, bc, guard, ax, ay;
        dx = ((m_px >>> 8) & 1023) - 320;
        dy = ((m_py >>> 8) & 1023) - 240;
        r2 = dx * dx + dy * dy;
        if (r2 < 16) r2 = 16;
        ex_num[0] = 100 * iabs(dx) * 256;
        ex_num[1] = 100 * iabs(dy) * 256;
        lat[0] = lx; lat[1] = ly;
        q[0] = 0; q[1] = 0;
        @(posedge pixel_clk); #1 frame_tick = 1'b1;
        @(posedge pixel_clk); #1 frame_tick = 1'b0;
        ph = 0; rc = 0; bc = 0; guard = 0;
        while (busy === 1'b1 && guard < 500) begin
            guard++; bc++;
            div_ack = 1'b0;
            frame_tick = (bc == tick_at);
            if (bc == pz) pause = 1'b1;
            if (bc == 1) begin
                check("r2_req_low", div_req, 0);
                if (spur) begin
                    div_ack = 1'b1;
                    div_quot = $urandom;
                end
            end
            if (div_req === 1'b1 && ph < 2) begin
                check("num", div_num, ex_num[ph]);
                check("den", div_den, r2);
                if (ph == 0 && rc == 0) begin
                    first_num = div_num;
                    first_den = div_den;
                end
                rc++;
                if (rc == lat[ph]) begin
                    div_ack = 1'b1;
                    if (rnd_q) div_quot = $urandom_range(0, 40000);
                    else       div_quot = div_num / div_den;
                    q[ph] = div_quot;
                    ph++; rc = 0;
                end
            end
            @(posedge pixel_clk); #1;
        end
        div_ack = 1'b0; frame_tick = 1'b0; pause = 1'b0;
        check("no_timeout", guard < 500, 1);
        check("busy_cycles", bc, 4 + lx + ly);
        check("acks", ph, 2);
        ax = (q[0] > 32767) ? 32767 : q[0];
        ay = (q[1] > 32767) ? 32767 : q[1];
        m_vx = wrap24(m_vx - sgn(dx) * ax);
        m_vy = wrap24(m_vy - sgn(dy) * ay);
        m_px = wrap24(m_px + m_vx);
        m_py = wrap24(m_py + m_vy);
        m_steps++;
        if (tick_at > 0) m_ovr = 1;
        check_outputs("step");
    endtask

    initial begin
        int bc, guard, lx, ly, ta;
        model_reset();
        repeat (3) @(posedge pixel_clk);
        #1 reset_n = 1'b1;
        @(posedge pixel_clk); #1;
        check_outputs("reset");
        check("reset_busy", busy, 0);
        check("reset_req", div_req, 0);
        check("reset_num", div_num, 0);
        check("reset_den", div_den, 0);

        // Canonical first step with a 3-cycle divider.
        run_step(3, 3, 0, 0, 0, 0);
        check("t2_num", first_num, 512000);
        check("t2_den", first_den, 400);
        check("t2_x", ship_x, 305);
        check("t2_y", ship_y, 245);
        check("t2_steps", step_count, 1);

        // Tick while busy is dropped but flagged.
        run_step(2, 2, 0, 0, 2, 0);
        repeat (5) @(posedge pixel_clk);
        #1;
        check("t3_idle", busy, 0);
        check("t3_ovr", overrun, 1);
        check("t3_steps", step_count, 2);

        // Paused tick is ignored.
        pause = 1'b1;
        @(posedge pixel_clk); #1 frame_tick = 1'b1;
        @(posedge pixel_clk); #1 frame_tick = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("t4_busy", busy, 0);
        check_outputs("t4");
        pause = 1'b0;

        // Ship parked at the centre: guarded divisor, no motion.
        @(posedge pixel_clk); #1 tick_c = 1'b1;
        @(posedge pixel_clk); #1 tick_c = 1'b0;
        bc = 0; guard = 0;
        while (busy_c === 1'b1 && guard < 100) begin
            guard++; bc++;
            ack_c = 1'b0;
            if (req_c === 1'b1) begin
                check("t5_num", num_c, 0);
                check("t5_den", den_c, 16);
                ack_c = 1'b1;
            end
            @(posedge pixel_clk); #1;
        end
        ack_c = 1'b0;
        check("t5_busy_cycles", bc, 6);
        check("t5_x", sx_c, 320);
        check("t5_y", sy_c, 240);
        check("t5_steps", steps_c, 1);
        check("t5_ovr", ovr_c, 0);

        for (int i = 0; i < 40; i++) begin
            lx = $urandom_range(1, 5);
            ly = $urandom_range(1, 5);
            ta = ($urandom % 4 == 0) ? $urandom_range(1, 4 + lx + ly) : 0;
            run_step(lx, ly, ($urandom % 3) == 0, $urandom % 2,
                     ta, ($urandom % 3 == 0) ? 3 : 0);
            repeat ($urandom_range(0, 3)) @(posedge pixel_clk);
        end

        // Reset while waiting on the divider.
        @(posedge pixel_clk); #1 frame_tick = 1'b1;
        @(posedge pixel_clk); #1 frame_tick = 1'b0;
        guard = 0;
        while (div_req !== 1'b1 && guard < 20) begin
            guard++;
            @(posedge pixel_clk); #1;
        end
        check("t6_in_div", div_req, 1);
        reset_n = 1'b0;
        @(posedge pixel_clk); #1;
        check("t6_req", div_req, 0);
        check("t6_busy", busy, 0);
        model_reset();
        check_outputs("t6");
        reset_n = 1'b1;
        run_step(1, 2, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
